// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default geometry, derived sizes
// and the packed status-flag bundle carried between the controller's processes.
package fifo_ctrl_pkg;

    localparam int BUS_SIZE_DEF   = 4;
    localparam int ADDR_WIDTH_DEF = 2;

    // Capacity is always a power of two so the pointers wrap naturally.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Occupancy needs one bit more than a pointer to represent "completely full".
    function automatic int count_w(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/memoria.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module memoria #(
    parameter int BUS_SIZE   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addressR,
    input  logic [ADDR_WIDTH-1:0] addressW,
    input  logic [BUS_SIZE-1:0]   data_in,
    output logic [BUS_SIZE-1:0]   data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [BUS_SIZE-1:0] mem_q [DEPTH];
    logic [BUS_SIZE-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[addressW] <= data_in;
        end
    end

    // Non-blocking read of the pre-write contents gives read-before-write.
    always_ff @(posedge clk) begin
        if (read) begin
            data_out_q <= mem_q[addressR];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller around memoria: pointer/occupancy tracking, registered
// status flags, a one-cycle read-valid qualifier and a sticky error flag.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int BUS_SIZE   = BUS_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BUS_SIZE-1:0]   data_in,
    input  logic [ADDR_WIDTH:0]   umbral_full,
    input  logic [ADDR_WIDTH:0]   umbral_empty,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int             DEPTH   = depth_of(ADDR_WIDTH);
    localparam int             CW      = count_w(ADDR_WIDTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    fifo_flags_t           flags_q, flags_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  push_ok, pop_ok;
    logic                  overflow, underflow;

    // A push into a full FIFO is still taken when a pop frees a slot the same cycle.
    always_comb begin
        push_ok   = push & (~flags_q.full | pop);
        pop_ok    = pop & ~flags_q.empty;
        overflow  = push & flags_q.full & ~pop;
        underflow = pop & flags_q.empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags are derived from the next occupancy so they move with fifo_count.
    always_comb begin
        flags_d              = flags_q;
        flags_d.full         = (count_d == DEPTH_C);
        flags_d.empty        = (count_d == '0);
        flags_d.almost_full  = (count_d >= umbral_full);
        flags_d.almost_empty = (count_d <= umbral_empty);
        valid_d              = pop_ok;
        error_d              = error_q | overflow | underflow;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= FLAGS_RESET;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    memoria #(
        .BUS_SIZE   (BUS_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk      (clk),
        .read     (pop_ok),
        .write    (push_ok),
        .addressR (rd_ptr_q),
        .addressW (wr_ptr_q),
        .data_in  (data_in),
        .data_out (data_out)
    );

    assign valid_out    = valid_q;
    assign fifo_count   = count_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign error        = error_q;

endmodule
